ov7670_capture: RTL and testbench

- Upstream stage of the QVGA display path.
- Captures the OV7670 parallel byte stream (cam_vsync, cam_href, cam_data) in the camera pclk domain.
- Assembles byte pairs into 16-bit RGB565 pixels and writes them to the QVGA frame buffer at linear addresses 0..H_PIXELS*V_LINES-1.
- The display stage reads the same buffer through its 17-bit read address.

---
 rtl/ov7670_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_ov7670_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// ov7670_capture
//   Captures the OV7670 parallel byte stream in the pclk domain, pairs bytes
//   into RGB565 pixels and writes them linearly into the QVGA frame buffer.
//
// Ports
//   pclk        camera pixel clock (only clock)
//   rst         synchronous reset, active-high
//   cam_vsync   OV7670 VSYNC, high pulse between frames
//   cam_href    OV7670 HREF, high while line bytes are valid
//   cam_data    OV7670 D[7:0]
//   wr_en       frame-buffer write strobe, one cycle per pixel
//   wr_addr     frame-buffer write address (linear, 0..H_PIXELS*V_LINES-1)
//   wr_data     RGB565 pixel {first byte, second byte}
//   frame_done  one-cycle pulse at the end of each captured frame
//   frame_ok    qualifies frame_done: frame had exact geometry, no errors
//   overrun     sticky, a pixel arrived past the last address; cleared at frame start
module ov7670_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              overrun
);

  // Counters saturate one past their nominal maximum so a long line or an
  // extra line can never wrap back onto a "good" value.
  localparam int COL_W = $clog2(H_PIXELS + 2);
  localparam int ROW_W = $clog2(V_LINES + 2);

  localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_PIXELS);
  localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_PIXELS + 1);
  localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(V_LINES);
  localparam logic [ROW_W-1:0]  ROW_SAT   = ROW_W'(V_LINES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic              vsync_r, vsync_d_r, href_r, href_d_r;
  logic [7:0]        data_r;
  logic [7:0]        hi_r;
  logic              phase_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [ADDR_W-1:0] addr_r;
  logic              full_r;
  logic              bad_r;

  logic              wr_en_r, frame_done_r, frame_ok_r, overrun_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [15:0]       wr_data_r;

  logic              vs_rise_s, vs_fall_s, href_fall_s;
  logic              frame_start_s, frame_end_s, byte_s, line_end_s;
  logic              line_bad_s;
  logic [ROW_W-1:0]  row_inc_s, row_end_s;
  logic              frame_ok_s;

  assign vs_rise_s   = vsync_r & ~vsync_d_r;
  assign vs_fall_s   = ~vsync_r & vsync_d_r;
  assign href_fall_s = href_d_r & ~href_r;

  // Line closes bad if its pixel count is wrong or an odd byte is pending.
  assign line_bad_s = (col_r != COL_FULL) | phase_r;
  assign row_inc_s  = (row_r == ROW_SAT) ? row_r : row_r + ROW_W'(1);
  // A line that closes on the very cycle the frame ends still counts.
  assign row_end_s  = href_fall_s ? row_inc_s : row_r;
  // href still high at vsync rise means a truncated line: frame is bad.
  assign frame_ok_s = (row_end_s == ROW_FULL) & ~bad_r & ~overrun_r & ~href_r
                      & ~(href_fall_s & line_bad_s);

  // Input register stage: all control works on these registered copies.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_r   <= 1'b0;
      vsync_d_r <= 1'b0;
      href_r    <= 1'b0;
      href_d_r  <= 1'b0;
      data_r    <= 8'h00;
    end else begin
      vsync_r   <= cam_vsync;
      vsync_d_r <= vsync_r;
      href_r    <= cam_href;
      href_d_r  <= href_r;
      data_r    <= cam_data;
    end
  end

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r <= ST_SYNC;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and per-cycle action strobes.
  always_comb begin
    next_state_s  = state_r;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    byte_s        = 1'b0;
    line_end_s    = 1'b0;
    case (state_r)
      ST_SYNC: begin
        if (vsync_r) begin
          next_state_s = ST_VBLANK;
        end else begin
          next_state_s = ST_SYNC;
        end
      end
      ST_VBLANK: begin
        if (vs_fall_s) begin
          next_state_s  = ST_ACTIVE;
          frame_start_s = 1'b1;
        end else begin
          next_state_s = ST_VBLANK;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise_s) begin
          next_state_s = ST_VBLANK;
          frame_end_s  = 1'b1;
        end else if (href_r) begin
          byte_s = 1'b1;
        end else if (href_fall_s) begin
          line_end_s = 1'b1;
        end else begin
          next_state_s = ST_ACTIVE;
        end
      end
      default: begin
        next_state_s = ST_SYNC;
      end
    endcase
  end

  // Datapath: byte pairing, addressing, line/frame accounting, outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hi_r         <= 8'h00;
      phase_r      <= 1'b0;
      col_r        <= '0;
      row_r        <= '0;
      addr_r       <= '0;
      full_r       <= 1'b0;
      bad_r        <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= 16'h0000;
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      // Phase only advances while bytes are flowing; any gap realigns it.
      phase_r      <= byte_s ? ~phase_r : 1'b0;

      if (frame_start_s) begin
        col_r     <= '0;
        row_r     <= '0;
        addr_r    <= '0;
        full_r    <= 1'b0;
        bad_r     <= 1'b0;
        overrun_r <= 1'b0;
      end

      if (frame_end_s) begin
        frame_done_r <= 1'b1;
        frame_ok_r   <= frame_ok_s;
      end

      if (byte_s) begin
        if (!phase_r) begin
          hi_r <= data_r;
        end else begin
          if (col_r != COL_SAT) begin
            col_r <= col_r + COL_W'(1);
          end
          if (full_r) begin
            overrun_r <= 1'b1;
          end else begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_r;
            wr_data_r <= {hi_r, data_r};
            // Address freezes once the last location has been written.
            if (addr_r == LAST_ADDR) begin
              full_r <= 1'b1;
            end else begin
              addr_r <= addr_r + ADDR_W'(1);
            end
          end
        end
      end

      if (line_end_s) begin
        if (line_bad_s) begin
          bad_r <= 1'b1;
        end
        row_r <= row_inc_s;
        col_r <= '0;
      end
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign frame_done = frame_done_r;
  assign frame_ok   = frame_ok_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x3 frame.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 3;
  localparam int AW = 17;

  logic          pclk = 1'b0;
  logic          rst;
  logic          cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done, frame_ok, overrun;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int pix       = 0;

  logic [AW-1:0] wa[$];
  logic [15:0]   wd[$];
  int            fd_cnt = 0;
  logic          fd_ok  = 1'b0;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_ok(frame_ok), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  // Record writes and frame_done events just after each active edge.
  always @(posedge pclk) begin
    #1;
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_ok  = frame_ok;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (got !== exp) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hi_b(input int p);
    hi_b = 8'h10 + 8'(p);
  endfunction

  function automatic logic [7:0] lo_b(input int p);
    lo_b = 8'h80 + 8'(p);
  endfunction

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge pclk);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
  endtask

  task automatic vs_high(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic vs_low(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  // One href-high line of n pixels, optionally followed by a dangling byte.
  task automatic send_line(input int n, input bit odd);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, hi_b(pix));
      cyc(1'b0, 1'b1, lo_b(pix));
      pix = pix + 1;
    end
    if (odd) cyc(1'b0, 1'b1, 8'hEE);
    vs_low(3);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    fd_cnt = 0;
    fd_ok  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    vs_low(3);
    @(posedge pclk); #1;
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    @(negedge pclk); rst = 1'b0;

    // Partial frame after reset is discarded until a vsync pulse.
    clear_log();
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    vs_high(4);
    check_val("sync_no_writes", 32'(wa.size()), 32'd0);
    check_val("sync_no_done", 32'(fd_cnt), 32'd0);

    // Good frame: addresses 0..11 in order with matching data.
    vs_low(3); clear_log(); pix = 0;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    vs_high(4);
    check_val("good_nwr", 32'(wa.size()), 32'd12);
    for (int i = 0; i < wa.size(); i++) begin
      check_val($sformatf("good_addr%0d", i), 32'(wa[i]), 32'(i));
      check_val($sformatf("good_data%0d", i), 32'(wd[i]), 32'({hi_b(i), lo_b(i)}));
    end
    check_val("good_done_cnt", 32'(fd_cnt), 32'd1);
    check_val("good_ok", 32'(fd_ok), 32'd1);
    check_val("good_overrun", 32'(overrun), 32'd0);

    // Byte pairing latency: 0xAB sampled at edge j, write at edge j+2.
    vs_low(3); clear_log();
    cyc(1'b0, 1'b1, 8'hAB);
    cyc(1'b0, 1'b1, 8'hCD);
    cyc(1'b0, 1'b0, 8'h00);
    check_val("abcd_early", 32'(wr_en), 32'd0);
    @(posedge pclk); #1;
    check_val("abcd_wr_en", 32'(wr_en), 32'd1);
    check_val("abcd_data", 32'(wr_data), 32'hABCD);
    check_val("abcd_addr", 32'(wr_addr), 32'd0);
    @(posedge pclk); #1;
    check_val("abcd_one_cycle", 32'(wr_en), 32'd0);
    vs_low(2);
    vs_high(4);
    check_val("abcd_frame_ok", 32'(fd_ok), 32'd0);

    // Wrong line length (4,5,3) marks the frame bad.
    vs_low(3); clear_log(); pix = 0;
    send_line(4, 1'b0); send_line(5, 1'b0); send_line(3, 1'b0);
    vs_high(4);
    check_val("long_nwr", 32'(wa.size()), 32'd12);
    check_val("long_done", 32'(fd_cnt), 32'd1);
    check_val("long_ok", 32'(fd_ok), 32'd0);
    check_val("long_overrun", 32'(overrun), 32'd0);

    // 13 pixels: last write at 11, overrun set, cleared at next frame start.
    vs_low(3); clear_log(); pix = 0;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    send_line(1, 1'b0);
    vs_high(4);
    check_val("ovr_nwr", 32'(wa.size()), 32'd12);
    check_val("ovr_last_addr", 32'(wa[$]), 32'd11);
    check_val("ovr_last_data", 32'(wd[$]), 32'({hi_b(11), lo_b(11)}));
    check_val("ovr_flag", 32'(overrun), 32'd1);
    check_val("ovr_ok", 32'(fd_ok), 32'd0);
    vs_low(3);
    check_val("ovr_cleared", 32'(overrun), 32'd0);

    // Dangling odd byte: one write, phase realigns for the next line.
    clear_log(); pix = 0;
    send_line(1, 1'b1);
    check_val("odd_nwr", 32'(wa.size()), 32'd1);
    send_line(1, 1'b0);
    vs_high(4);
    check_val("odd_nwr2", 32'(wa.size()), 32'd2);
    check_val("odd_realign", 32'(wd[1]), 32'({hi_b(1), lo_b(1)}));
    check_val("odd_addr1", 32'(wa[1]), 32'd1);
    check_val("odd_ok", 32'(fd_ok), 32'd0);

    // Reset mid-line suppresses the pending write; restart needs a vsync pulse.
    vs_low(3); clear_log(); pix = 0;
    cyc(1'b0, 1'b1, hi_b(0));
    cyc(1'b0, 1'b1, lo_b(0));
    cyc(1'b0, 1'b1, hi_b(1)); rst = 1'b1;
    @(posedge pclk); #1;
    check_val("rst_mid_wr_en", 32'(wr_en), 32'd0);
    vs_low(2); rst = 1'b0;
    clear_log(); pix = 0;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    check_val("rst_mid_no_writes", 32'(wa.size()), 32'd0);
    vs_high(4); vs_low(3); clear_log(); pix = 0;
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    vs_high(4);
    check_val("rst_restart_nwr", 32'(wa.size()), 32'd12);
    check_val("rst_restart_addr0", 32'(wa[0]), 32'd0);
    check_val("rst_restart_ok", 32'(fd_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
